mem_bus_arbiter: RTL and testbench

- Two-master, one-slave arbiter for the single Avalon-style memory port (address/read/write/waitrequest/writedata/byteenable/readdata).
- Lets the CPU bus port (master 0) share external memory with a second requester (master 1, e.g. a DMA or test loader).
- Round-robin grant per transfer; holds the grant across slave waitrequest stalls.
- Watchdog aborts a transfer that stalls too long.

---
 rtl/mem_bus_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-master, one-slave Avalon-style memory arbiter with round-robin grant per
// transfer, grant held across waitrequest stalls, and a stall watchdog.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CW      = 8
) (
  input  logic        clk,
  input  logic        reset,

  input  logic [31:0] m0_address,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [31:0] m0_writedata,
  input  logic [3:0]  m0_byteenable,
  output logic [31:0] m0_readdata,
  output logic        m0_waitrequest,

  input  logic [31:0] m1_address,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [31:0] m1_writedata,
  input  logic [3:0]  m1_byteenable,
  output logic [31:0] m1_readdata,
  output logic        m1_waitrequest,

  output logic [31:0] s_address,
  output logic        s_read,
  output logic        s_write,
  output logic [31:0] s_writedata,
  output logic [3:0]  s_byteenable,
  input  logic [31:0] s_readdata,
  input  logic        s_waitrequest,

  output logic [1:0]  grant,
  output logic        timeout_err
);

  // Handshake: a master's request (read|write) acts as valid and must stay
  // stable with its address/data while its waitrequest is 1; a transfer
  // completes on the rising edge where request=1 and waitrequest=0.

  localparam logic [1:0]    ST_IDLE     = 2'd0;
  localparam logic [1:0]    ST_BUSY0    = 2'd1;
  localparam logic [1:0]    ST_BUSY1    = 2'd2;
  localparam logic [CW-1:0] TIMEOUT_VAL = CW'(TIMEOUT);
  localparam logic [31:0]   ABORT_DATA  = 32'hDEADBEEF;

  logic [1:0]    state_q, state_d;
  logic          last_q, last_d;
  logic [CW-1:0] wdog_q, wdog_d;
  logic          timeout_err_q, timeout_err_d;

  logic req0, req1;
  logic busy, owner, owner_req, abort;

  assign req0      = m0_read | m0_write;
  assign req1      = m1_read | m1_write;
  assign busy      = (state_q == ST_BUSY0) || (state_q == ST_BUSY1);
  assign owner     = (state_q == ST_BUSY1);
  assign owner_req = owner ? req1 : req0;
  assign abort     = busy && s_waitrequest && (wdog_q == TIMEOUT_VAL);

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    wdog_d        = wdog_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      ST_IDLE: begin
        wdog_d = '0;
        // last_q names the master served most recently, so the other one wins a tie
        if (req0 && req1) begin
          state_d = last_q ? ST_BUSY0 : ST_BUSY1;
        end else if (req0) begin
          state_d = ST_BUSY0;
        end else if (req1) begin
          state_d = ST_BUSY1;
        end
      end
      ST_BUSY0, ST_BUSY1: begin
        if (abort) begin
          state_d       = ST_IDLE;
          last_d        = owner;
          wdog_d        = '0;
          timeout_err_d = 1'b1;
        end else if (!owner_req) begin
          // Owner withdrew mid-transfer: not a completed transfer, fairness unchanged
          state_d = ST_IDLE;
          wdog_d  = '0;
        end else if (!s_waitrequest) begin
          state_d = ST_IDLE;
          last_d  = owner;
          wdog_d  = '0;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        wdog_d  = '0;
      end
    endcase
  end

  always_comb begin
    s_address      = m0_address;
    s_writedata    = m0_writedata;
    s_byteenable   = m0_byteenable;
    s_read         = 1'b0;
    s_write        = 1'b0;
    m0_waitrequest = req0;
    m1_waitrequest = req1;
    m0_readdata    = s_readdata;
    m1_readdata    = s_readdata;
    case (state_q)
      ST_BUSY0: begin
        s_read         = m0_read;
        s_write        = m0_write;
        m0_waitrequest = s_waitrequest;
        if (abort) begin
          s_read         = 1'b0;
          s_write        = 1'b0;
          m0_waitrequest = 1'b0;
          m0_readdata    = ABORT_DATA;
        end
      end
      ST_BUSY1: begin
        s_address      = m1_address;
        s_writedata    = m1_writedata;
        s_byteenable   = m1_byteenable;
        s_read         = m1_read;
        s_write        = m1_write;
        m1_waitrequest = s_waitrequest;
        if (abort) begin
          s_read         = 1'b0;
          s_write        = 1'b0;
          m1_waitrequest = 1'b0;
          m1_readdata    = ABORT_DATA;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      last_q        <= 1'b1;
      wdog_q        <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      wdog_q        <= wdog_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign grant       = {state_q == ST_BUSY1, state_q == ST_BUSY0};
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter (TIMEOUT=4): single transfers, alternation,
// write pass-through, watchdog abort, reset mid-transfer and abandoned requests.
module tb_mem_bus_arbiter;

  logic        clk;
  logic        reset;
  logic [31:0] m0_address, m0_writedata, m0_readdata;
  logic        m0_read, m0_write, m0_waitrequest;
  logic [3:0]  m0_byteenable;
  logic [31:0] m1_address, m1_writedata, m1_readdata;
  logic        m1_read, m1_write, m1_waitrequest;
  logic [3:0]  m1_byteenable;
  logic [31:0] s_address, s_writedata, s_readdata;
  logic        s_read, s_write, s_waitrequest;
  logic [3:0]  s_byteenable;
  logic [1:0]  grant;
  logic        timeout_err;

  int n_checks;
  int n_errors;

  mem_bus_arbiter #(.TIMEOUT(4), .CW(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .m0_address     (m0_address),
    .m0_read        (m0_read),
    .m0_write       (m0_write),
    .m0_writedata   (m0_writedata),
    .m0_byteenable  (m0_byteenable),
    .m0_readdata    (m0_readdata),
    .m0_waitrequest (m0_waitrequest),
    .m1_address     (m1_address),
    .m1_read        (m1_read),
    .m1_write       (m1_write),
    .m1_writedata   (m1_writedata),
    .m1_byteenable  (m1_byteenable),
    .m1_readdata    (m1_readdata),
    .m1_waitrequest (m1_waitrequest),
    .s_address      (s_address),
    .s_read         (s_read),
    .s_write        (s_write),
    .s_writedata    (s_writedata),
    .s_byteenable   (s_byteenable),
    .s_readdata     (s_readdata),
    .s_waitrequest  (s_waitrequest),
    .grant          (grant),
    .timeout_err    (timeout_err)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [1:0] alt_grant [8];

  initial begin
    n_checks = 0;
    n_errors = 0;
    alt_grant = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};

    reset = 1'b1;
    m0_address = 32'h0; m0_read = 1'b0; m0_write = 1'b0; m0_writedata = 32'h0; m0_byteenable = 4'h0;
    m1_address = 32'h0; m1_read = 1'b0; m1_write = 1'b0; m1_writedata = 32'h0; m1_byteenable = 4'h0;
    s_readdata = 32'h0; s_waitrequest = 1'b1;

    // reset with m0 already requesting a read of 0x10
    m0_address = 32'h0000_0010; m0_read = 1'b1; m0_byteenable = 4'hF;
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_s_read", 32'(s_read), 32'h0);
    check("rst_s_write", 32'(s_write), 32'h0);
    check("rst_terr", 32'(timeout_err), 32'h0);
    check("rst_m0_wait", 32'(m0_waitrequest), 32'h1);
    check("rst_m1_wait", 32'(m1_waitrequest), 32'h0);

    // read with two stall cycles
    tick(); #1;
    check("rd_b1_grant", 32'(grant), 32'h1);
    check("rd_b1_s_read", 32'(s_read), 32'h1);
    check("rd_b1_addr", s_address, 32'h0000_0010);
    check("rd_b1_m0_wait", 32'(m0_waitrequest), 32'h1);
    tick(); #1;
    check("rd_b2_s_read", 32'(s_read), 32'h1);
    check("rd_b2_m0_wait", 32'(m0_waitrequest), 32'h1);
    tick();
    s_waitrequest = 1'b0; s_readdata = 32'h1234_5678;
    #1;
    check("rd_b3_s_read", 32'(s_read), 32'h1);
    check("rd_b3_m0_wait", 32'(m0_waitrequest), 32'h0);
    check("rd_b3_data", m0_readdata, 32'h1234_5678);
    tick();
    m0_read = 1'b0;
    #1;
    check("rd_idle_grant", 32'(grant), 32'h0);
    check("rd_idle_s_read", 32'(s_read), 32'h0);

    // both masters reading continuously, zero-wait memory (m0 served last)
    m0_read = 1'b1; m1_read = 1'b1; s_readdata = 32'h0BAD_F00D;
    for (int i = 0; i < 8; i++) begin
      #1;
      check($sformatf("alt_grant_%0d", i), 32'(grant), 32'(alt_grant[i]));
      check($sformatf("alt_m0_wait_%0d", i), 32'(m0_waitrequest), (alt_grant[i] == 2'b01) ? 32'h0 : 32'h1);
      check($sformatf("alt_m1_wait_%0d", i), 32'(m1_waitrequest), (alt_grant[i] == 2'b10) ? 32'h0 : 32'h1);
      if (alt_grant[i] == 2'b10) check($sformatf("alt_m1_data_%0d", i), m1_readdata, 32'h0BAD_F00D);
      tick();
    end
    m0_read = 1'b0; m1_read = 1'b0;

    // m1 write, one stall cycle
    m1_write = 1'b1; m1_writedata = 32'hCAFE_F00D; m1_byteenable = 4'b0011;
    m1_address = 32'h0000_0100; s_waitrequest = 1'b1;
    #1;
    check("wr_idle_m1_wait", 32'(m1_waitrequest), 32'h1);
    check("wr_idle_s_write", 32'(s_write), 32'h0);
    tick(); #1;
    check("wr_grant", 32'(grant), 32'h2);
    check("wr_s_write", 32'(s_write), 32'h1);
    check("wr_s_read", 32'(s_read), 32'h0);
    check("wr_data", s_writedata, 32'hCAFE_F00D);
    check("wr_be", 32'(s_byteenable), 32'h3);
    check("wr_addr", s_address, 32'h0000_0100);
    check("wr_m1_wait", 32'(m1_waitrequest), 32'h1);
    check("wr_m0_wait", 32'(m0_waitrequest), 32'h0);
    s_waitrequest = 1'b0;
    #1;
    check("wr_done_m1_wait", 32'(m1_waitrequest), 32'h0);
    tick();
    m1_write = 1'b0;
    #1;
    check("wr_idle_grant", 32'(grant), 32'h0);
    check("wr_idle_s_write2", 32'(s_write), 32'h0);

    // watchdog: four stalled cycles, abort on the fifth
    m0_read = 1'b1; m0_address = 32'h0000_0020; s_waitrequest = 1'b1; s_readdata = 32'h1111_2222;
    tick();
    for (int k = 1; k <= 4; k++) begin
      #1;
      check($sformatf("wd_stall_wait_%0d", k), 32'(m0_waitrequest), 32'h1);
      check($sformatf("wd_stall_s_read_%0d", k), 32'(s_read), 32'h1);
      tick();
    end
    #1;
    check("wd_abort_wait", 32'(m0_waitrequest), 32'h0);
    check("wd_abort_data", m0_readdata, 32'hDEAD_BEEF);
    check("wd_abort_s_read", 32'(s_read), 32'h0);
    check("wd_abort_grant", 32'(grant), 32'h1);
    check("wd_abort_m1_data", m1_readdata, 32'h1111_2222);
    check("wd_abort_terr", 32'(timeout_err), 32'h0);
    tick();
    m0_read = 1'b0;
    #1;
    check("wd_terr_set", 32'(timeout_err), 32'h1);
    check("wd_idle_grant", 32'(grant), 32'h0);
    tick(); tick(); #1;
    check("wd_terr_held", 32'(timeout_err), 32'h1);

    // reset while m1 is stalled
    m1_read = 1'b1; s_waitrequest = 1'b1;
    tick(); #1;
    check("rb_grant", 32'(grant), 32'h2);
    check("rb_s_read", 32'(s_read), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("rb_post_grant", 32'(grant), 32'h0);
    check("rb_post_s_read", 32'(s_read), 32'h0);
    check("rb_post_terr", 32'(timeout_err), 32'h0);
    check("rb_post_m1_wait", 32'(m1_waitrequest), 32'h1);
    m0_read = 1'b1; s_waitrequest = 1'b0;
    tick(); #1;
    check("rb_tie_grant", 32'(grant), 32'h1);
    check("rb_tie_m1_wait", 32'(m1_waitrequest), 32'h1);
    tick();
    m0_read = 1'b0; m1_read = 1'b0;

    // m0 drops its request while stalled (last=0 on entry)
    m0_read = 1'b1; s_waitrequest = 1'b1;
    tick();
    m1_read = 1'b1;
    #1;
    check("ab_grant", 32'(grant), 32'h1);
    check("ab_m1_wait", 32'(m1_waitrequest), 32'h1);
    tick();
    m0_read = 1'b0;
    #1;
    check("ab_m0_wait_pass", 32'(m0_waitrequest), 32'h1);
    tick(); #1;
    check("ab_idle_grant", 32'(grant), 32'h0);
    check("ab_idle_s_read", 32'(s_read), 32'h0);
    check("ab_idle_m1_wait", 32'(m1_waitrequest), 32'h1);
    tick(); #1;
    check("ab_m1_grant", 32'(grant), 32'h2);
    s_waitrequest = 1'b0;
    tick();
    // last=1 now; m0 wins the tie, then abandons, and must win the next tie too
    m0_read = 1'b1; s_waitrequest = 1'b1;
    #1;
    check("ab2_idle_grant", 32'(grant), 32'h0);
    tick(); #1;
    check("ab2_grant", 32'(grant), 32'h1);
    tick();
    m0_read = 1'b0;
    tick();
    m0_read = 1'b1;
    #1;
    check("ab2_idle_grant2", 32'(grant), 32'h0);
    tick(); #1;
    check("ab2_regrant_m0", 32'(grant), 32'h1);
    s_waitrequest = 1'b0;
    tick();
    m0_read = 1'b0; m1_read = 1'b0;
    #1;
    check("end_grant", 32'(grant), 32'h0);
    check("end_terr", 32'(timeout_err), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
